cv32e40p_rf_ctx_engine: RTL and testbench

- Initiator-side sequencer for the integer/FP register file. Saves the architectural register context to an outbound valid/ready stream, or restores it from an inbound stream.
- Drives one RF read port (save) and one RF write port (restore).
- Used for vector-accelerator context switch and debug dump while the core pipeline is halted. The core guarantees it does not write the RF while busy_o=1.

---
 rtl/cv32e40p_rf_ctx_engine_if.sv | 49 ++++
 rtl/cv32e40p_rf_ctx_engine.sv | 164 ++++++++++++++++
 tb/tb_cv32e40p_rf_ctx_engine.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_rf_ctx_engine_if.sv
// Handshake, stream and register-file port bundle of the RF context engine.
// master = engine side, slave = core/RF/stream side.
interface cv32e40p_rf_ctx_engine_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  // Control
  logic                  save_req_i;
  logic                  restore_req_i;
  logic                  abort_i;
  logic                  busy_o;
  logic                  done_o;

  // Register file read port (save) and write port (restore)
  logic [ADDR_WIDTH-1:0] rf_raddr_o;
  logic [DATA_WIDTH-1:0] rf_rdata_i;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic                  rf_we_o;

  // Outbound save stream
  logic                  sv_valid_o;
  logic                  sv_ready_i;
  logic [ADDR_WIDTH-1:0] sv_addr_o;
  logic [DATA_WIDTH-1:0] sv_data_o;

  // Inbound restore stream
  logic                  rs_valid_i;
  logic                  rs_ready_o;
  logic [DATA_WIDTH-1:0] rs_data_i;

  modport master (
    input  save_req_i, restore_req_i, abort_i,
    input  rf_rdata_i, sv_ready_i, rs_valid_i, rs_data_i,
    output busy_o, done_o,
    output rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
    output sv_valid_o, sv_addr_o, sv_data_o,
    output rs_ready_o
  );

  modport slave (
    output save_req_i, restore_req_i, abort_i,
    output rf_rdata_i, sv_ready_i, rs_valid_i, rs_data_i,
    input  busy_o, done_o,
    input  rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
    input  sv_valid_o, sv_addr_o, sv_data_o,
    input  rs_ready_o
  );
endinterface

// File: rtl/cv32e40p_rf_ctx_engine.sv
// Register-file context engine: walks x1..x31 (and f0..f31 when an FP bank exists),
// streaming them out on save or writing them back from an inbound stream on restore.
module cv32e40p_rf_ctx_engine #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FPU        = 0,
  parameter int PULP_ZFINX = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  cv32e40p_rf_ctx_engine_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [ADDR_WIDTH:0]   idx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // The FP bank is walked only when it exists as a separate bank.
  localparam bit    WALK_FP   = (FPU != 0) && (PULP_ZFINX == 0);
  localparam idx_t  LAST_IDX  = WALK_FP ? idx_t'(63) : idx_t'(31);
  localparam addr_t LAST_ADDR = addr_t'(LAST_IDX);

  state_t state_q, state_d;

  // One spare bit lets idx step past LAST without wrapping back onto x0.
  idx_t   idx_q;

  logic   sv_valid_q;
  addr_t  sv_addr_q;
  data_t  sv_data_q;

  logic   we_q;
  addr_t  waddr_q;
  data_t  wdata_q;

  logic   idx_in_walk;
  logic   sv_hs;
  logic   sv_load;
  logic   last_sv_hs;
  logic   rs_ready;
  logic   rs_hs;
  logic   last_write;

  assign idx_in_walk = (idx_q <= LAST_IDX);
  assign sv_hs       = sv_valid_q & bus.sv_ready_i;
  assign last_sv_hs  = sv_hs & (sv_addr_q == LAST_ADDR);

  // The output register refills when empty or when its beat leaves this cycle.
  assign sv_load     = (state_q == SAVE) & ~bus.abort_i & idx_in_walk
                     & (~sv_valid_q | bus.sv_ready_i);

  // Ready falls with abort so no beat is accepted that will never be written.
  assign rs_ready    = (state_q == RESTORE) & ~bus.abort_i & idx_in_walk;
  assign rs_hs       = rs_ready & bus.rs_valid_i;
  assign last_write  = we_q & (waddr_q == LAST_ADDR);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.save_req_i) begin
          state_d = SAVE;
        end else if (bus.restore_req_i) begin
          state_d = RESTORE;
        end
      end
      SAVE: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (last_sv_hs) begin
          state_d = DONE;
        end
      end
      RESTORE: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (last_write) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= idx_t'(1);
      sv_valid_q <= 1'b0;
      sv_addr_q  <= '0;
      sv_data_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      // An accepted restore beat always lands, even if abort follows it.
      we_q <= rs_hs;
      if (rs_hs) begin
        waddr_q <= addr_t'(idx_q);
        wdata_q <= bus.rs_data_i;
      end

      unique case (state_q)
        IDLE: begin
          idx_q <= idx_t'(1);
        end
        SAVE: begin
          if (bus.abort_i) begin
            sv_valid_q <= 1'b0;
          end else if (sv_load) begin
            sv_valid_q <= 1'b1;
            sv_addr_q  <= addr_t'(idx_q);
            sv_data_q  <= bus.rf_rdata_i;
            idx_q      <= idx_q + idx_t'(1);
          end else if (sv_hs) begin
            sv_valid_q <= 1'b0;
          end
        end
        RESTORE: begin
          if (rs_hs) begin
            idx_q <= idx_q + idx_t'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = (state_q == DONE);
  assign bus.rf_raddr_o = ((state_q == SAVE) && idx_in_walk) ? addr_t'(idx_q) : '0;
  assign bus.rf_waddr_o = waddr_q;
  assign bus.rf_wdata_o = wdata_q;
  assign bus.rf_we_o    = we_q;
  assign bus.sv_valid_o = sv_valid_q;
  assign bus.sv_addr_o  = sv_addr_q;
  assign bus.sv_data_o  = sv_data_q;
  assign bus.rs_ready_o = rs_ready;

endmodule

// File: tb/tb_cv32e40p_rf_ctx_engine.sv
// Directed bench for the RF context engine: an integer-only instance (dut0)
// and an instance with a separate FP bank (dut1) share clock and reset.
module tb_cv32e40p_rf_ctx_engine;

  logic clk;
  logic rst;

  int checks;
  int errors;

  cv32e40p_rf_ctx_engine_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) if0 ();
  cv32e40p_rf_ctx_engine_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) if1 ();

  cv32e40p_rf_ctx_engine #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(0), .PULP_ZFINX(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  cv32e40p_rf_ctx_engine #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .PULP_ZFINX(0)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-side register file model for dut0 (written only by the tasks).
  logic [31:0] rd0 [64];
  assign if0.rf_rdata_i = rd0[if0.rf_raddr_o];
  assign if1.rf_rdata_i = 32'h0;

  // Write logs, sampled mid-cycle; each rf_we_o pulse is seen exactly once.
  logic [5:0]  wr0_addr [$];
  logic [31:0] wr0_data [$];
  logic [5:0]  wr1_addr [$];
  logic [31:0] wr1_data [$];

  always @(negedge clk) begin
    if (!rst && if0.rf_we_o) begin
      wr0_addr.push_back(if0.rf_waddr_o);
      wr0_data.push_back(if0.rf_wdata_o);
    end
    if (!rst && if1.rf_we_o) begin
      wr1_addr.push_back(if1.rf_waddr_o);
      wr1_data.push_back(if1.rf_wdata_o);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload_rd0();
    for (int n = 0; n < 64; n++) rd0[n] = 32'hA500_0000 + 32'(n);
  endtask

  task automatic test_reset();
    checks++;
    if ({if0.busy_o, if0.done_o, if0.sv_valid_o, if0.rs_ready_o, if0.rf_we_o,
         if0.rf_raddr_o, if0.rf_waddr_o, if0.rf_wdata_o, if0.sv_addr_o, if0.sv_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_dut0: busy=%b done=%b svv=%b rsr=%b we=%b raddr=%h waddr=%h wdata=%h sva=%h svd=%h, expected all 0",
               if0.busy_o, if0.done_o, if0.sv_valid_o, if0.rs_ready_o, if0.rf_we_o,
               if0.rf_raddr_o, if0.rf_waddr_o, if0.rf_wdata_o, if0.sv_addr_o, if0.sv_data_o);
    end
    checks++;
    if ({if1.busy_o, if1.done_o, if1.sv_valid_o, if1.rs_ready_o, if1.rf_we_o,
         if1.rf_raddr_o, if1.rf_waddr_o, if1.rf_wdata_o, if1.sv_addr_o, if1.sv_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_dut1: busy=%b done=%b svv=%b rsr=%b we=%b, expected all 0",
               if1.busy_o, if1.done_o, if1.sv_valid_o, if1.rs_ready_o, if1.rf_we_o);
    end
  endtask

  task automatic test_save_full();
    preload_rd0();
    if0.sv_ready_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b0;
    checks++;
    if (if0.busy_o !== 1'b1 || if0.sv_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL save_entry: busy=%b valid=%b, expected busy=1 valid=0", if0.busy_o, if0.sv_valid_o);
    end
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      checks++;
      if (if0.sv_valid_o !== 1'b1 || if0.sv_addr_o !== 6'(k) ||
          if0.sv_data_o !== 32'hA500_0000 + 32'(k)) begin
        errors++;
        $display("FAIL save_beat: valid=%b addr=%0d data=%h, expected valid=1 addr=%0d data=%h",
                 if0.sv_valid_o, if0.sv_addr_o, if0.sv_data_o, k, 32'hA500_0000 + 32'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (if0.done_o !== 1'b1 || if0.busy_o !== 1'b1 || if0.sv_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL save_done: done=%b busy=%b valid=%b, expected 1 1 0", if0.done_o, if0.busy_o, if0.sv_valid_o);
    end
    @(negedge clk);
    checks++;
    if (if0.done_o !== 1'b0 || if0.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL save_idle: done=%b busy=%b, expected 0 0", if0.done_o, if0.busy_o);
    end
  endtask

  task automatic test_save_backpressure();
    logic        pat [4];
    int          exp_addr;
    logic        prev_stall;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    if0.sv_ready_i = 1'b0;
    @(negedge clk); if0.save_req_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b0;
    exp_addr   = 1;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    for (int c = 0; c < 300 && exp_addr <= 31; c++) begin
      @(negedge clk);
      if0.sv_ready_i = pat[c % 4];
      if (prev_stall) begin
        checks++;
        if (if0.sv_valid_o !== 1'b1 || if0.sv_addr_o !== prev_addr || if0.sv_data_o !== prev_data) begin
          errors++;
          $display("FAIL bp_hold: valid=%b addr=%0d data=%h, expected 1 %0d %h",
                   if0.sv_valid_o, if0.sv_addr_o, if0.sv_data_o, prev_addr, prev_data);
        end
      end
      if (if0.sv_valid_o === 1'b1) begin
        checks++;
        if (if0.sv_addr_o !== 6'(exp_addr) || if0.sv_data_o !== 32'hA500_0000 + 32'(exp_addr)) begin
          errors++;
          $display("FAIL bp_beat: addr=%0d data=%h, expected %0d %h",
                   if0.sv_addr_o, if0.sv_data_o, exp_addr, 32'hA500_0000 + 32'(exp_addr));
        end
        if (if0.sv_ready_i) exp_addr++;
      end
      prev_stall = (if0.sv_valid_o === 1'b1) && !if0.sv_ready_i;
      prev_addr  = if0.sv_addr_o;
      prev_data  = if0.sv_data_o;
    end
    checks++;
    if (exp_addr != 32) begin
      errors++;
      $display("FAIL bp_count: last expected addr reached %0d, required 32", exp_addr);
    end
    @(negedge clk);
    if0.sv_ready_i = 1'b1;
    checks++;
    if (if0.done_o !== 1'b1 || if0.sv_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b valid=%b, expected 1 0", if0.done_o, if0.sv_valid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_restore_fp();
    int   k;
    int   base;
    logic hs;
    base = wr1_addr.size();
    @(negedge clk); if1.restore_req_i = 1'b1;
    @(negedge clk); if1.restore_req_i = 1'b0;
    checks++;
    if (if1.busy_o !== 1'b1 || if1.rs_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rs_start: busy=%b ready=%b, expected 1 1", if1.busy_o, if1.rs_ready_o);
    end
    k  = 0;
    hs = 1'b0;
    for (int c = 0; c < 200 && (k < 63 || hs); c++) begin
      if1.rs_valid_i = (k < 63);
      if1.rs_data_i  = 32'h1000 + 32'(k);
      checks++;
      if (hs) begin
        if (if1.rf_we_o !== 1'b1 || if1.rf_waddr_o !== 6'(k) || if1.rf_wdata_o !== 32'h1000 + 32'(k - 1) ||
            (k == 63 && if1.rs_ready_o !== 1'b0)) begin
          errors++;
          $display("FAIL rs_write: we=%b addr=%0d data=%h ready=%b, expected we=1 addr=%0d data=%h",
                   if1.rf_we_o, if1.rf_waddr_o, if1.rf_wdata_o, if1.rs_ready_o, k, 32'h1000 + 32'(k - 1));
        end
      end else if (if1.rf_we_o !== 1'b0) begin
        errors++;
        $display("FAIL rs_idle_we: we=%b, expected 0", if1.rf_we_o);
      end
      hs = if1.rs_valid_i && (if1.rs_ready_o === 1'b1);
      if (hs) k++;
      @(negedge clk);
    end
    if1.rs_valid_i = 1'b0;
    checks++;
    if (k != 63 || if1.done_o !== 1'b1 || if1.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rs_done: beats=%0d done=%b busy=%b, expected 63 1 1", k, if1.done_o, if1.busy_o);
    end
    @(negedge clk);
    checks++;
    if (wr1_addr.size() - base != 63) begin
      errors++;
      $display("FAIL rs_write_count: got %0d writes, expected 63", wr1_addr.size() - base);
    end else begin
      for (int i = 0; i < 63; i++) begin
        checks++;
        if (wr1_addr[base + i] !== 6'(i + 1) || wr1_data[base + i] !== 32'h1000 + 32'(i)) begin
          errors++;
          $display("FAIL rs_rf_content: write %0d addr=%0d data=%h, expected addr=%0d data=%h",
                   i, wr1_addr[base + i], wr1_data[base + i], i + 1, 32'h1000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_both_requests();
    int   beats;
    logic rs_seen;
    logic done_seen;
    int   base;
    base = wr0_addr.size();
    if0.sv_ready_i = 1'b1;
    if0.rs_valid_i = 1'b1;
    if0.rs_data_i  = 32'hFFFF_0000;
    @(negedge clk); if0.save_req_i = 1'b1; if0.restore_req_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b0; if0.restore_req_i = 1'b0;
    beats = 0; rs_seen = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      if (if0.rs_ready_o !== 1'b0) rs_seen = 1'b1;
      if (if0.done_o === 1'b1) done_seen = 1'b1;
      if (if0.sv_valid_o === 1'b1) begin
        checks++;
        if (if0.sv_addr_o !== 6'(beats + 1)) begin
          errors++;
          $display("FAIL both_beat: addr=%0d, expected %0d", if0.sv_addr_o, beats + 1);
        end
        beats++;
      end
      @(negedge clk);
    end
    if0.rs_valid_i = 1'b0;
    checks++;
    if (beats != 31 || rs_seen || !done_seen || wr0_addr.size() != base) begin
      errors++;
      $display("FAIL both_save_wins: beats=%0d rs_ready_seen=%b done_seen=%b writes=%0d, expected 31 0 1 0",
               beats, rs_seen, done_seen, wr0_addr.size() - base);
    end
  endtask

  task automatic test_abort_restore();
    int   hs;
    int   base;
    logic done_seen;
    base = wr0_addr.size();
    @(negedge clk); if0.restore_req_i = 1'b1;
    @(negedge clk); if0.restore_req_i = 1'b0;
    hs = 0;
    if0.rs_valid_i = 1'b1;
    for (int c = 0; c < 50 && hs < 5; c++) begin
      if0.rs_data_i = 32'h2000 + 32'(hs);
      if (if0.rs_ready_o === 1'b1) hs++;
      @(negedge clk);
    end
    if0.abort_i = 1'b1;
    #1;
    checks++;
    if (hs != 5 || if0.rs_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: handshakes=%0d ready=%b, expected 5 0", hs, if0.rs_ready_o);
    end
    done_seen = (if0.done_o === 1'b1);
    @(negedge clk);
    if0.abort_i    = 1'b0;
    if0.rs_valid_i = 1'b0;
    checks++;
    if (if0.busy_o !== 1'b0 || if0.rs_ready_o !== 1'b0 || if0.rf_we_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ready=%b we=%b, expected 0 0 0", if0.busy_o, if0.rs_ready_o, if0.rf_we_o);
    end
    for (int c = 0; c < 4; c++) begin
      if (if0.done_o === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_seen || wr0_addr.size() - base != 5) begin
      errors++;
      $display("FAIL abort_writes: done_seen=%b writes=%0d, expected 0 5", done_seen, wr0_addr.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr0_addr[base + i] !== 6'(i + 1) || wr0_data[base + i] !== 32'h2000 + 32'(i)) begin
          errors++;
          $display("FAIL abort_write_seq: write %0d addr=%0d data=%h, expected %0d %h",
                   i, wr0_addr[base + i], wr0_data[base + i], i + 1, 32'h2000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_save();
    logic found;
    logic done_seen;
    preload_rd0();
    if0.sv_ready_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      found = (if0.sv_valid_o === 1'b1) && (if0.sv_addr_o === 6'd10);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_reach_beat10: beat 10 not seen within budget");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({if0.busy_o, if0.done_o, if0.sv_valid_o, if0.rs_ready_o, if0.rf_we_o,
         if0.rf_raddr_o, if0.rf_waddr_o, if0.rf_wdata_o, if0.sv_addr_o, if0.sv_data_o} !== '0) begin
      errors++;
      $display("FAIL rst_async_clear: busy=%b valid=%b raddr=%h sva=%h svd=%h, expected all 0",
               if0.busy_o, if0.sv_valid_o, if0.rf_raddr_o, if0.sv_addr_o, if0.sv_data_o);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); if0.save_req_i = 1'b1;
    @(negedge clk); if0.save_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (if0.sv_valid_o !== 1'b1 || if0.sv_addr_o !== 6'd1 || if0.sv_data_o !== 32'hA500_0001) begin
      errors++;
      $display("FAIL rst_restart: valid=%b addr=%0d data=%h, expected 1 1 a5000001",
               if0.sv_valid_o, if0.sv_addr_o, if0.sv_data_o);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      @(negedge clk);
      done_seen = (if0.done_o === 1'b1);
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL rst_restart_done: done never asserted within budget");
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    {if0.save_req_i, if0.restore_req_i, if0.abort_i, if0.sv_ready_i, if0.rs_valid_i} = '0;
    {if1.save_req_i, if1.restore_req_i, if1.abort_i, if1.sv_ready_i, if1.rs_valid_i} = '0;
    if0.rs_data_i = '0;
    if1.rs_data_i = '0;
    for (int n = 0; n < 64; n++) rd0[n] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_save_full();
    test_save_backpressure();
    test_restore_fp();
    test_both_requests();
    test_abort_restore();
    test_reset_mid_save();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
